memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, number of 32-bit data-memory words (power of two).
REQ-002 The block SHALL have parameter DATA_W, default 32, data path width.
REQ-003 The block SHALL have input clk, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have input Stall, width 1: hold the MEM/WB register; suppress the memory write.
REQ-006 The block SHALL have input Flush, width 1: squash the instruction currently in MEM.
REQ-007 The block SHALL have inputs EnableMemoryRead and EnableMemoryWrite, width 1 each: load and store controls.
REQ-008 The block SHALL have inputs RegWriteIn (width 1) and WriteRegisterIn (width 5): destination control, passed through.
REQ-009 The block SHALL have input ALUResult, width DATA_W: byte address for memory ops, or the result to pass through.
REQ-010 The block SHALL have input WriteData, width DATA_W: store data.
REQ-011 The block SHALL have outputs WbEnableMemoryRead and WbRegWrite (width 1 each) and WbWriteRegister (width 5): registered controls to write-back.
REQ-012 The block SHALL have outputs WbDataMemoryOutput and WbALUResult, width DATA_W each: registered load data and ALU result.
REQ-013 The block SHALL have output MisalignedAccess, width 1: registered, one-cycle misalignment flag.

Function
REQ-014 The word index SHALL be ALUResult[log2(DEPTH)+1:2]; higher address bits are ignored (addresses wrap modulo DEPTH words).
REQ-015 The access SHALL be misaligned when ALUResult[1:0]!=0 and either EnableMemoryRead or EnableMemoryWrite is 1.
REQ-016 The store SHALL commit at the clk edge only when EnableMemoryWrite=1, aligned, Stall=0, Flush=0 and reset=0.
REQ-017 The load data SHALL be read combinationally from the indexed word and captured into WbDataMemoryOutput at the same edge, giving 1-cycle latency to write-back.
REQ-018 When both read and write are enabled, the read SHALL return the pre-write (old) word and the write SHALL commit.
REQ-019 With Stall=0 and Flush=0, all Wb* outputs SHALL load from the corresponding inputs each edge.
REQ-020 A misaligned access SHALL perform no write, capture WbDataMemoryOutput=0, force WbRegWrite=0 and WbEnableMemoryRead=0, and set MisalignedAccess=1 for exactly one cycle.
REQ-021 With Stall=1 and Flush=0, all Wb* outputs SHALL hold, MisalignedAccess SHALL go 0, and memory SHALL be unchanged.
REQ-022 With Flush=1, a bubble SHALL be loaded regardless of Stall: all Wb* outputs 0, MisalignedAccess 0, no write.
REQ-023 Priority SHALL be reset > Flush > Stall > normal.

Reset
REQ-024 While reset=1 at an edge, all Wb* outputs and MisalignedAccess SHALL become 0 and every memory word SHALL be cleared to 0.
REQ-025 A store presented in the same cycle as reset SHALL be discarded.
REQ-026 The first normal capture SHALL occur at the first edge with reset=0.

Structure
REQ-027 A shared package SHALL hold DATA_W, REG_ADDR_W=5, the default DEPTH and the bubble value constants.
REQ-028 The storage SHALL be a sub-module data_memory with sync write, combinational read and sync clear; memory_stage SHALL contain the alignment check, write gating and MEM/WB register.

Verification
REQ-029 Store 0xDEADBEEF at address 0x10, then load 0x10 with RegWriteIn=1 and WriteRegisterIn=8 -> next cycle WbDataMemoryOutput=0xDEADBEEF, WbRegWrite=1, WbWriteRegister=8.
REQ-030 Load at address 0x12 -> MisalignedAccess=1 for one cycle, WbRegWrite=0, WbDataMemoryOutput=0; memory is unchanged.
REQ-031 Store 0x1 at 0x400 with DEPTH=256, then load 0x0 -> 0x1 (wrap-around).
REQ-032 Store with Stall=1, then load the same address -> old value; Wb* outputs held during the stall.
REQ-033 Stall=1 and Flush=1 on a store of 0x55 -> bubble (all Wb* outputs 0) and no write; reset asserted mid-sequence -> all outputs 0 and a subsequent load returns 0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_stage_pkg
// Shared definitions for the MEM pipeline stage: default widths and depth,
// the bubble values loaded into MEM/WB on a flush or reset, the per-edge
// action of the MEM/WB register, and the alignment helper.
// -----------------------------------------------------------------------------
package memory_stage_pkg;

    // Data path width and register-file address width.
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Default number of 32-bit words in the data memory (power of two).
    localparam int DEFAULT_DEPTH = 256;

    // Values loaded into MEM/WB when a bubble is inserted.
    localparam logic                  BUBBLE_CTRL = 1'b0;
    localparam logic [REG_ADDR_W-1:0] BUBBLE_REG  = '0;
    localparam logic [DATA_W-1:0]     BUBBLE_DATA = '0;

    // What the MEM/WB register does at the next rising edge, in priority order.
    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_STALL,
        ACT_CAPTURE
    } stageActionT;

    // A memory access is misaligned when it is not on a word boundary.
    // Instructions that do not touch memory are never flagged.
    function automatic logic isMisaligned(
        input logic [1:0] byteOffset,
        input logic       memRead,
        input logic       memWrite
    );
        return (byteOffset != 2'b00) && (memRead || memWrite);
    endfunction

endpackage : memory_stage_pkg

// File: rtl/memory_stage_data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Word-addressed data memory for the MEM stage.
//   - write: synchronous, one word per rising edge when writeEnable is high
//   - read : combinational from the addressed word (returns the pre-write
//            word when a write to the same address is pending)
//   - clear: synchronous; every word is zeroed while reset is high
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high clear of all words
//   writeEnable  in   commit writeData to mem[address] at the edge
//   address      in   word index, $clog2(DEPTH) bits
//   writeData    in   DATA_W-bit store data
//   readData     out  DATA_W-bit word at address (combinational)
// -----------------------------------------------------------------------------
module data_memory
    import memory_stage_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = memory_stage_pkg::DATA_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    // NOTE: clearing every word on reset forces this array into flops rather
    // than a RAM macro; the stage must guarantee an all-zero memory after
    // reset, so the clear is kept deliberately.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEnable) begin
            mem[address] <= writeData;
        end
    end

    // Asynchronous read: a load sees the word as it was before this edge.
    assign readData = mem[address];

endmodule : data_memory

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// MEM stage of the pipeline: alignment check, store gating, data memory and
// the MEM/WB pipeline register.
//
// Priority at each rising edge: reset > Flush > Stall > normal capture.
//   reset   : MEM/WB cleared, MisalignedAccess cleared, memory zeroed,
//             any store presented in that cycle discarded
//   Flush   : bubble loaded into MEM/WB (all zeros), no store
//   Stall   : MEM/WB holds, MisalignedAccess drops to 0, no store
//   normal  : MEM/WB captures this instruction; an aligned store commits
// A misaligned load/store performs no write, captures zero load data, kills
// RegWrite and MemoryRead toward write-back, and raises MisalignedAccess for
// one cycle.
//
// Ports
//   clk                 in   clock, rising edge
//   reset               in   synchronous active-high reset
//   Stall               in   hold MEM/WB, suppress the store
//   Flush               in   squash the instruction in MEM
//   EnableMemoryRead    in   load control
//   EnableMemoryWrite   in   store control
//   RegWriteIn          in   destination write enable (passed through)
//   WriteRegisterIn     in   destination register (passed through)
//   ALUResult           in   byte address for loads/stores, or ALU result
//   WriteData           in   store data
//   WbEnableMemoryRead  out  registered load control
//   WbRegWrite          out  registered destination write enable
//   WbWriteRegister     out  registered destination register
//   WbDataMemoryOutput  out  registered load data
//   WbALUResult         out  registered ALU result
//   MisalignedAccess    out  registered one-cycle misalignment flag
// -----------------------------------------------------------------------------
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = memory_stage_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  EnableMemoryRead,
    input  logic                  EnableMemoryWrite,
    input  logic                  RegWriteIn,
    input  logic [REG_ADDR_W-1:0] WriteRegisterIn,
    input  logic [DATA_W-1:0]     ALUResult,
    input  logic [DATA_W-1:0]     WriteData,
    output logic                  WbEnableMemoryRead,
    output logic                  WbRegWrite,
    output logic [REG_ADDR_W-1:0] WbWriteRegister,
    output logic [DATA_W-1:0]     WbDataMemoryOutput,
    output logic [DATA_W-1:0]     WbALUResult,
    output logic                  MisalignedAccess
);

    localparam int ADDR_W = $clog2(DEPTH);

    // -------------------------------------------------------------------------
    // Address decode and alignment
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] wordIndex;
    logic              misaligned;
    logic              unusedAddrBits;

    // Bits above the word index are ignored, so addresses wrap modulo DEPTH.
    assign wordIndex      = ALUResult[ADDR_W+1:2];
    assign unusedAddrBits = ^ALUResult[DATA_W-1:ADDR_W+2];
    assign misaligned     = isMisaligned(ALUResult[1:0], EnableMemoryRead,
                                         EnableMemoryWrite);

    // -------------------------------------------------------------------------
    // Edge action: one decision shared by the store gate and MEM/WB.
    // -------------------------------------------------------------------------
    stageActionT stageAction;

    // NOTE: the default is assigned before any branch so every path drives
    // stageAction; a missing default would infer a latch.
    always_comb begin
        stageAction = ACT_CAPTURE;
        if (reset) begin
            stageAction = ACT_RESET;
        end else if (Flush) begin
            stageAction = ACT_FLUSH;
        end else if (Stall) begin
            stageAction = ACT_STALL;
        end
    end

    // Only an aligned store on a normal capture edge reaches the memory.
    logic memWriteEnable;
    assign memWriteEnable = (stageAction == ACT_CAPTURE) && EnableMemoryWrite
                            && !misaligned;

    // -------------------------------------------------------------------------
    // Data memory
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] memReadData;

    data_memory #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_data_memory (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (memWriteEnable),
        .address     (wordIndex),
        .writeData   (WriteData),
        .readData    (memReadData)
    );

    // -------------------------------------------------------------------------
    // MEM/WB pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        unique case (stageAction)
            ACT_RESET, ACT_FLUSH: begin
                WbEnableMemoryRead <= BUBBLE_CTRL;
                WbRegWrite         <= BUBBLE_CTRL;
                WbWriteRegister    <= BUBBLE_REG;
                WbDataMemoryOutput <= DATA_W'(BUBBLE_DATA);
                WbALUResult        <= DATA_W'(BUBBLE_DATA);
                MisalignedAccess   <= 1'b0;
            end
            ACT_STALL: begin
                // Wb* hold their values; the flag is a one-cycle pulse and
                // must not persist across a stall.
                MisalignedAccess   <= 1'b0;
            end
            default: begin
                WbEnableMemoryRead <= EnableMemoryRead && !misaligned;
                WbRegWrite         <= RegWriteIn && !misaligned;
                WbWriteRegister    <= WriteRegisterIn;
                WbDataMemoryOutput <= misaligned ? DATA_W'(BUBBLE_DATA)
                                                 : memReadData;
                WbALUResult        <= ALUResult;
                MisalignedAccess   <= misaligned;
            end
        endcase
    end

endmodule : memory_stage

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Directed scenarios followed by a randomized run, each edge checked against
// a behavioural model: a word array plus the expected MEM/WB contents,
// updated from the stage's rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_memory_stage;

    localparam int DEPTH  = 256;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              Stall = 1'b0;
    logic              Flush = 1'b0;
    logic              EnableMemoryRead = 1'b0;
    logic              EnableMemoryWrite = 1'b0;
    logic              RegWriteIn = 1'b0;
    logic [4:0]        WriteRegisterIn = '0;
    logic [DATA_W-1:0] ALUResult = '0;
    logic [DATA_W-1:0] WriteData = '0;
    logic              WbEnableMemoryRead;
    logic              WbRegWrite;
    logic [4:0]        WbWriteRegister;
    logic [DATA_W-1:0] WbDataMemoryOutput;
    logic [DATA_W-1:0] WbALUResult;
    logic              MisalignedAccess;

    memory_stage #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Stall              (Stall),
        .Flush              (Flush),
        .EnableMemoryRead   (EnableMemoryRead),
        .EnableMemoryWrite  (EnableMemoryWrite),
        .RegWriteIn         (RegWriteIn),
        .WriteRegisterIn    (WriteRegisterIn),
        .ALUResult          (ALUResult),
        .WriteData          (WriteData),
        .WbEnableMemoryRead (WbEnableMemoryRead),
        .WbRegWrite         (WbRegWrite),
        .WbWriteRegister    (WbWriteRegister),
        .WbDataMemoryOutput (WbDataMemoryOutput),
        .WbALUResult        (WbALUResult),
        .MisalignedAccess   (MisalignedAccess)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] refMem [DEPTH];
    logic        expRead;
    logic        expRegWrite;
    logic [4:0]  expWriteReg;
    logic [31:0] expData;
    logic [31:0] expAlu;
    logic        expMis;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the stage's rules,
    // clock once, then compare every output 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input logic stall,
                        input logic flush, input logic rd, input logic wr,
                        input logic rw, input logic [4:0] wreg,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int  idx;
        bit  mis;
        reset             = rst;
        Stall             = stall;
        Flush             = flush;
        EnableMemoryRead  = rd;
        EnableMemoryWrite = wr;
        RegWriteIn        = rw;
        WriteRegisterIn   = wreg;
        ALUResult         = addr;
        WriteData         = wdata;

        idx = int'((addr / 4) % DEPTH);
        mis = ((addr % 4) != 0) && (rd || wr);
        if (rst || flush) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
            end
            expRead = 0; expRegWrite = 0; expWriteReg = 0;
            expData = 0; expAlu = 0; expMis = 0;
        end else if (stall) begin
            expMis = 0;
        end else begin
            expData     = mis ? 32'h0 : refMem[idx];
            expRead     = rd && !mis;
            expRegWrite = rw && !mis;
            expWriteReg = wreg;
            expAlu      = addr;
            expMis      = mis;
            if (wr && !mis) refMem[idx] = wdata;
        end

        @(posedge clk);
        #1;
        check({tag, ".rd"},   32'(WbEnableMemoryRead), 32'(expRead));
        check({tag, ".rw"},   32'(WbRegWrite),         32'(expRegWrite));
        check({tag, ".wreg"}, 32'(WbWriteRegister),    32'(expWriteReg));
        check({tag, ".data"}, WbDataMemoryOutput,      expData);
        check({tag, ".alu"},  WbALUResult,             expAlu);
        check({tag, ".mis"},  32'(MisalignedAccess),   32'(expMis));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) refMem[i] = 'x;

        // Reset: everything zero.          tag      rst st fl rd wr rw wreg addr          wdata
        step("reset0", 1, 0, 0, 0, 0, 0, 5'd0, 32'h0,        32'h0);
        step("reset1", 1, 0, 0, 0, 1, 1, 5'd3, 32'h10,       32'h1234);
        check("reset.data", WbDataMemoryOutput, 32'h0);

        // Store then load, destination passed through.
        step("st10",   0, 0, 0, 0, 1, 0, 5'd0, 32'h10,       32'hDEADBEEF);
        step("ld10",   0, 0, 0, 1, 0, 1, 5'd8, 32'h10,       32'h0);
        check("ld10.const", WbDataMemoryOutput, 32'hDEADBEEF);
        check("ld10.wreg8", 32'(WbWriteRegister), 32'd8);

        // Misaligned load, misaligned store, then confirm memory unchanged.
        step("ld12",   0, 0, 0, 1, 0, 1, 5'd9, 32'h12,       32'h0);
        check("ld12.flag", 32'(MisalignedAccess), 32'd1);
        step("st11",   0, 0, 0, 0, 1, 0, 5'd0, 32'h11,       32'h0BADF00D);
        step("ld10b",  0, 0, 0, 1, 0, 1, 5'd8, 32'h10,       32'h0);
        check("ld10b.const", WbDataMemoryOutput, 32'hDEADBEEF);
        check("ld10b.flag",  32'(MisalignedAccess), 32'd0);

        // Wrap-around: 0x400 is word 256 which aliases word 0.
        step("st400",  0, 0, 0, 0, 1, 0, 5'd0, 32'h400,      32'h1);
        step("ld0",    0, 0, 0, 1, 0, 1, 5'd2, 32'h0,        32'h0);
        check("ld0.wrap", WbDataMemoryOutput, 32'h1);

        // Store under stall is dropped and Wb* hold.
        step("st20",   0, 0, 0, 0, 1, 0, 5'd0, 32'h20,       32'hAAAA5555);
        step("stallA", 0, 1, 0, 0, 1, 1, 5'd7, 32'h20,       32'h12345678);
        step("stallB", 0, 1, 0, 1, 0, 1, 5'd6, 32'h24,       32'h0);
        check("stall.hold", WbALUResult, 32'h20);
        step("ld20",   0, 0, 0, 1, 0, 1, 5'd4, 32'h20,       32'h0);
        check("ld20.old", WbDataMemoryOutput, 32'hAAAA5555);

        // Read-and-write same word: old value returned, new value committed.
        step("rw20",   0, 0, 0, 1, 1, 1, 5'd5, 32'h20,       32'hCAFEF00D);
        check("rw20.old", WbDataMemoryOutput, 32'hAAAA5555);
        step("ld20b",  0, 0, 0, 1, 0, 1, 5'd5, 32'h20,       32'h0);
        check("ld20b.new", WbDataMemoryOutput, 32'hCAFEF00D);

        // Misaligned flag followed by a stall must drop to 0.
        step("ld23",   0, 0, 0, 1, 0, 1, 5'd1, 32'h23,       32'h0);
        step("stallC", 0, 1, 0, 0, 0, 0, 5'd0, 32'h0,        32'h0);

        // Flush beats stall: bubble and no write.
        step("flush",  0, 1, 1, 0, 1, 1, 5'd3, 32'h30,       32'h55);
        check("flush.alu", WbALUResult, 32'h0);
        step("ld30",   0, 0, 0, 1, 0, 1, 5'd3, 32'h30,       32'h0);
        check("ld30.zero", WbDataMemoryOutput, 32'h0);

        // Reset mid-sequence with a store present; memory comes back zero.
        step("rst2",   1, 0, 0, 0, 1, 1, 5'd3, 32'h10,       32'hFFFFFFFF);
        step("ld10c",  0, 0, 0, 1, 0, 1, 5'd8, 32'h10,       32'h0);
        check("ld10c.zero", WbDataMemoryOutput, 32'h0);
        step("ld20c",  0, 0, 0, 1, 0, 1, 5'd8, 32'h20,       32'h0);

        // Randomized traffic over a few words with aliasing high bits.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] addr;
            logic        rst;
            addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
            rst = ($urandom_range(0, 63) == 0);
            step("rand", rst, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 addr, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_memory_stage
